// File: rtl/mem_stage_sram_ctrl_pkg.sv
// rtl/mem_stage_sram_ctrl_pkg.sv - shared types and constants for the MEM-stage SRAM controller
package mem_stage_sram_ctrl_pkg;

    // Controller sequence: idle, low halfword, high halfword, completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int          SRAM_DW       = 16;
    localparam int          SRAM_AW_DEF   = 18;

    // Wait-counter width; covers WAIT_CYCLES up to 15.
    localparam int          WAIT_CW       = 4;

endpackage

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// rtl/mem_stage_sram_ctrl_sram_wait_counter.sv - loadable down-counter with zero flag, one run per SRAM halfword
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         load load_val_i (has priority over dec_i)
//   load_val_i     reload value
//   dec_i          decrement by one, saturating at zero
//   zero_o         count is zero
module mem_stage_sram_ctrl_sram_wait_counter
    import mem_stage_sram_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [WAIT_CW-1:0] load_val_i,
    input  logic               dec_i,
    output logic               zero_o
);

    logic [WAIT_CW-1:0] count_q;
    logic [WAIT_CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - {{(WAIT_CW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage controller splitting 32-bit loads/stores into two waited 16-bit SRAM accesses
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN    load / store request (both high = store)
//   ALU_out               byte address; BASE_ADDR maps to SRAM word 0, bits [1:0] ignored
//   Val_RM                store data
//   mem_rdata             registered load result
//   ready                 pipeline may advance
//   sram_addr             halfword address
//   sram_dq_out/_oe       write data and its tri-state enable
//   sram_dq_in            read data from SRAM
//   sram_we_n             active-low write strobe
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_out,
    input  logic [31:0]        Val_RM,
    output logic [31:0]        mem_rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    localparam int                 WW          = SRAM_AW - 1;
    localparam logic [WAIT_CW-1:0] RELOAD      = WAIT_CW'(WAIT_CYCLES - 1);
    // With a single wait cycle there is no spare cycle to release the strobe
    // early, so the strobe covers the whole access.
    localparam logic               SINGLE_WAIT = (WAIT_CYCLES == 1);

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic [WW-1:0] word_q,  word_d;
    logic [31:0]   data_q,  data_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          req;
    logic [WW-1:0] word_in;
    logic          cnt_load;
    logic          cnt_dec;
    logic          cnt_zero;
    logic          hi_sel;
    logic          oe_c;
    logic          we_n_c;
    logic          ready_c;

    assign req     = MEM_R_EN | MEM_W_EN;
    // Offset wraps modulo 2^32; only the word bits that fit the SRAM survive.
    assign word_in = WW'((ALU_out - BASE_ADDR) >> 2);

    mem_stage_sram_ctrl_sram_wait_counter u_wait_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (RELOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        word_d   = word_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        hi_sel   = 1'b0;
        oe_c     = 1'b0;
        we_n_c   = 1'b1;
        ready_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_c = ~req;
                if (req) begin
                    write_d  = MEM_W_EN;
                    word_d   = word_in;
                    data_d   = Val_RM;
                    cnt_load = 1'b1;
                    state_d  = ST_LO;
                end
            end
            ST_LO: begin
                oe_c   = write_q;
                we_n_c = ~(write_q & (~cnt_zero | SINGLE_WAIT));
                if (cnt_zero) begin
                    if (!write_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    cnt_load = 1'b1;
                    state_d  = ST_HI;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HI: begin
                hi_sel = 1'b1;
                oe_c   = write_q;
                we_n_c = ~(write_q & (~cnt_zero | SINGLE_WAIT));
                if (cnt_zero) begin
                    if (!write_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                // Request is still high here while the pipeline advances;
                // always return to IDLE so it is not taken a second time.
                hi_sel  = 1'b1;
                ready_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            word_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            word_q  <= word_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    // Address and data stay on the high half through DONE for hold time.
    assign sram_addr   = {word_q, hi_sel};
    assign sram_dq_out = hi_sel ? data_q[31:16] : data_q[15:0];
    assign sram_dq_oe  = oe_c;
    assign sram_we_n   = we_n_c;
    assign ready       = ready_c;
    assign mem_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - self-checking bench for mem_stage_sram_ctrl at WAIT_CYCLES 3, 1 and 5
module tb_mem_stage_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        r_en  [3];
    logic        w_en  [3];
    logic [31:0] alu   [3];
    logic [31:0] vrm   [3];
    logic [31:0] rdata [3];
    logic        rdy   [3];
    logic [17:0] saddr [3];
    logic [15:0] dqo   [3];
    logic [15:0] dqi   [3];
    logic        oe    [3];
    logic        wen   [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_inst
            logic [15:0] mem [0:262143];
            mem_stage_sram_ctrl #(
                .WAIT_CYCLES ((g == 0) ? 3 : ((g == 1) ? 1 : 5))
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .MEM_R_EN    (r_en[g]),
                .MEM_W_EN    (w_en[g]),
                .ALU_out     (alu[g]),
                .Val_RM      (vrm[g]),
                .mem_rdata   (rdata[g]),
                .ready       (rdy[g]),
                .sram_addr   (saddr[g]),
                .sram_dq_out (dqo[g]),
                .sram_dq_oe  (oe[g]),
                .sram_dq_in  (dqi[g]),
                .sram_we_n   (wen[g])
            );
            assign dqi[g] = mem[saddr[g]];
            always @(posedge clk) begin
                if (wen[g] === 1'b0 && oe[g] === 1'b1) mem[saddr[g]] <= dqo[g];
            end
        end
    endgenerate

    // Reference model: word contents per instance, expected mem_rdata per instance.
    logic [31:0] refm [int];
    logic [31:0] exp_rd [3];

    // Results of the most recent access.
    int          r_stall;
    logic [17:0] r_al, r_ah;
    int          r_wlo, r_whi;
    bit          r_stable;

    function automatic int wc(int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 5);
    endfunction

    function automatic int word_of(logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off / 4) % 32'h20000);
    endfunction

    function automatic int exp_strobe(int w);
        return (w == 1) ? 1 : w - 1;
    endfunction

    // Drives one request and measures it; returns just after the edge ending DONE.
    task automatic access(input int idx, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, input bit skip_edge);
        int          w;
        logic [31:0] old;
        bit          done;
        w    = wc(idx);
        done = 0;
        if (!skip_edge) begin
            @(posedge clk); #1;
        end
        old = rdata[idx];
        w_en[idx] = wr; r_en[idx] = !wr; alu[idx] = a; vrm[idx] = d;
        r_stall = 0; r_wlo = 0; r_whi = 0; r_stable = 1; r_al = '0; r_ah = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (n <= w && rdata[idx] !== old) r_stable = 0;
            if (n == 1) r_al = saddr[idx];
            if (n == w + 1) r_ah = saddr[idx];
            if (wen[idx] === 1'b0) begin
                if (n >= 1 && n <= w) r_wlo++;
                else if (n > w && n <= 2 * w) r_whi++;
            end
            if (rdy[idx] === 1'b1) begin
                done = 1;
                break;
            end
            r_stall++;
        end
        if (!done) r_stall = -1;
        @(posedge clk); #1;
        if (!hold) begin
            w_en[idx] = 0; r_en[idx] = 0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %0b want 1", i, rdy[i]); end
            n_checks++; if (wen[i] !== 1'b1) begin n_fail++; $display("FAIL reset_we_n[%0d]: got %0b want 1", i, wen[i]); end
            n_checks++; if (oe[i] !== 1'b0) begin n_fail++; $display("FAIL reset_oe[%0d]: got %0b want 0", i, oe[i]); end
            n_checks++; if (rdata[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", i, rdata[i]); end
            n_checks++; if (saddr[i] !== 18'h0) begin n_fail++; $display("FAIL reset_addr[%0d]: got %h want 0", i, saddr[i]); end
            n_checks++; if (dqo[i] !== 16'h0) begin n_fail++; $display("FAIL reset_dq_out[%0d]: got %h want 0", i, dqo[i]); end
        end
    endtask

    task automatic test_store_load();
        access(0, 1, 32'd1028, 32'hDEADBEEF, 0, 0);
        refm[word_of(32'd1028)] = 32'hDEADBEEF;
        n_checks++; if (r_stall !== 7) begin n_fail++; $display("FAIL st_stall: got %0d want 7", r_stall); end
        n_checks++; if (r_al !== 18'd2 || r_ah !== 18'd3) begin n_fail++; $display("FAIL st_addr: got %h/%h want 2/3", r_al, r_ah); end
        n_checks++; if (r_wlo !== 2 || r_whi !== 2) begin n_fail++; $display("FAIL st_strobe: got %0d/%0d want 2/2", r_wlo, r_whi); end
        n_checks++; if (g_inst[0].mem[2] !== 16'hBEEF) begin n_fail++; $display("FAIL st_hw2: got %h want beef", g_inst[0].mem[2]); end
        n_checks++; if (g_inst[0].mem[3] !== 16'hDEAD) begin n_fail++; $display("FAIL st_hw3: got %h want dead", g_inst[0].mem[3]); end
        n_checks++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL st_rdata_hold: got %h want 0", rdata[0]); end
        access(0, 0, 32'd1028, 32'h0, 0, 0);
        n_checks++; if (r_stall !== 7) begin n_fail++; $display("FAIL ld_stall: got %0d want 7", r_stall); end
        n_checks++; if (r_wlo !== 0 || r_whi !== 0) begin n_fail++; $display("FAIL ld_strobe: got %0d/%0d want 0/0", r_wlo, r_whi); end
        n_checks++; if (rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ld_rdata: got %h want deadbeef", rdata[0]); end
    endtask

    task automatic test_latency();
        for (int i = 1; i < 3; i++) begin
            logic [31:0] d;
            logic [31:0] a;
            int w;
            w = wc(i);
            d = $urandom;
            a = 32'd1024 + 4 * $urandom_range(0, 15);
            access(i, 1, a, d, 0, 0);
            n_checks++; if (r_stall !== 2 * w + 1) begin n_fail++; $display("FAIL lat_st_stall[w=%0d]: got %0d want %0d", w, r_stall, 2 * w + 1); end
            n_checks++; if (r_wlo !== exp_strobe(w) || r_whi !== exp_strobe(w)) begin n_fail++; $display("FAIL lat_strobe[w=%0d]: got %0d/%0d want %0d", w, r_wlo, r_whi, exp_strobe(w)); end
            access(i, 0, a, 32'h0, 0, 0);
            n_checks++; if (r_stall !== 2 * w + 1) begin n_fail++; $display("FAIL lat_ld_stall[w=%0d]: got %0d want %0d", w, r_stall, 2 * w + 1); end
            n_checks++; if (rdata[i] !== d) begin n_fail++; $display("FAIL lat_ld_data[w=%0d]: got %h want %h", w, rdata[i], d); end
        end
    endtask

    task automatic test_addr_boundaries();
        access(0, 1, 32'd1024, 32'h11112222, 0, 0);
        n_checks++; if (r_al !== 18'h0 || r_ah !== 18'h1) begin n_fail++; $display("FAIL addr_base: got %h/%h want 0/1", r_al, r_ah); end
        access(0, 1, 32'd1027, 32'hA5A55A5A, 0, 0);
        n_checks++; if (r_al !== 18'h0 || r_ah !== 18'h1) begin n_fail++; $display("FAIL addr_unaligned: got %h/%h want 0/1", r_al, r_ah); end
        refm[0] = 32'hA5A55A5A;
        access(0, 0, 32'd1024, 32'h0, 0, 0);
        n_checks++; if (rdata[0] !== 32'hA5A55A5A) begin n_fail++; $display("FAIL addr_unaligned_data: got %h want a5a55a5a", rdata[0]); end
        access(0, 1, 32'd1020, 32'h0BADF00D, 0, 0);
        refm[word_of(32'd1020)] = 32'h0BADF00D;
        n_checks++; if (r_al !== 18'h3FFFE || r_ah !== 18'h3FFFF) begin n_fail++; $display("FAIL addr_wrap: got %h/%h want 3fffe/3ffff", r_al, r_ah); end
        n_checks++; if (g_inst[0].mem[18'h3FFFE] !== 16'hF00D) begin n_fail++; $display("FAIL addr_wrap_hw: got %h want f00d", g_inst[0].mem[18'h3FFFE]); end
        access(0, 0, 32'd1020, 32'h0, 0, 0);
        n_checks++; if (rdata[0] !== 32'h0BADF00D) begin n_fail++; $display("FAIL addr_wrap_data: got %h want 0badf00d", rdata[0]); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] a_hold;
        access(0, 1, 32'd1100, 32'h12345678, 0, 0);
        access(0, 1, 32'd1104, 32'h9ABCDEF0, 0, 0);
        refm[word_of(32'd1100)] = 32'h12345678;
        refm[word_of(32'd1104)] = 32'h9ABCDEF0;
        access(0, 0, 32'd1100, 32'h0, 1, 0);
        n_checks++; if (rdata[0] !== 32'h12345678) begin n_fail++; $display("FAIL b2b_first: got %h want 12345678", rdata[0]); end
        access(0, 0, 32'd1104, 32'h0, 0, 1);
        n_checks++; if (r_stall !== 7) begin n_fail++; $display("FAIL b2b_second_stall: got %0d want 7", r_stall); end
        n_checks++; if (r_stable !== 1'b1) begin n_fail++; $display("FAIL b2b_first_stable: got %0b want 1", r_stable); end
        n_checks++; if (rdata[0] !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL b2b_second: got %h want 9abcdef0", rdata[0]); end
        a_hold = saddr[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++; if (rdy[0] !== 1'b1 || saddr[0] !== a_hold) begin n_fail++; $display("FAIL b2b_no_third: ready %0b addr %h want 1 %h", rdy[0], saddr[0], a_hold); end
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk); #1;
        w_en[0] = 1; r_en[0] = 0; alu[0] = 32'd1200; vrm[0] = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (wen[0] !== 1'b0) begin n_fail++; $display("FAIL mid_pre_we_n: got %0b want 0", wen[0]); end
        rst = 1'b1;
        #1;
        n_checks++; if (wen[0] !== 1'b1) begin n_fail++; $display("FAIL mid_we_n: got %0b want 1", wen[0]); end
        n_checks++; if (oe[0] !== 1'b0) begin n_fail++; $display("FAIL mid_oe: got %0b want 0", oe[0]); end
        n_checks++; if (g_inst[0].u_dut.state_q !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", g_inst[0].u_dut.state_q); end
        w_en[0] = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b want 1", rdy[0]); end
        n_checks++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL mid_rdata: got %h want 0", rdata[0]); end
        for (int i = 0; i < 3; i++) exp_rd[i] = 32'h0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            int          idx;
            int          key;
            logic [31:0] a;
            logic [31:0] d;
            idx = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) a = 32'd1024 - 4 * $urandom_range(1, 4) + $urandom_range(0, 3);
            else a = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            key = idx * 32'h20000 + word_of(a);
            if (refm.exists(key) && $urandom_range(0, 1) == 1) begin
                access(idx, 0, a, $urandom, 0, 0);
                exp_rd[idx] = refm[key];
                n_checks++; if (rdata[idx] !== exp_rd[idx]) begin n_fail++; $display("FAIL rnd_load[%0d] a=%h: got %h want %h", t, a, rdata[idx], exp_rd[idx]); end
            end else begin
                d = $urandom;
                access(idx, 1, a, d, 0, 0);
                refm[key] = d;
                n_checks++; if (r_wlo !== exp_strobe(wc(idx)) || r_whi !== exp_strobe(wc(idx))) begin n_fail++; $display("FAIL rnd_strobe[%0d]: got %0d/%0d want %0d", t, r_wlo, r_whi, exp_strobe(wc(idx))); end
                n_checks++; if (rdata[idx] !== exp_rd[idx]) begin n_fail++; $display("FAIL rnd_rdata_hold[%0d]: got %h want %h", t, rdata[idx], exp_rd[idx]); end
            end
            n_checks++; if (r_stall !== 2 * wc(idx) + 1) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", t, r_stall, 2 * wc(idx) + 1); end
        end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL idle_ready[%0d]: got %0b want 1", c, rdy[0]); end
            n_checks++; if (wen[0] !== 1'b1 || oe[0] !== 1'b0) begin n_fail++; $display("FAIL idle_bus[%0d]: we_n %0b oe %0b want 1 0", c, wen[0], oe[0]); end
            n_checks++; if (rdata[0] !== exp_rd[0]) begin n_fail++; $display("FAIL idle_rdata[%0d]: got %h want %h", c, rdata[0], exp_rd[0]); end
        end
    endtask

    // Keys in refm for instance 0 are plain word indices; instances 1 and 2
    // keep their own SRAMs and are only used through the random test.
    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_en[i] = 0; w_en[i] = 0; alu[i] = '0; vrm[i] = '0; exp_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        test_store_load();
        test_latency();
        test_addr_boundaries();
        test_back_to_back();
        test_mid_reset();
        refm.delete();
        test_random();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- MEM-stage memory controller directly downstream of the execute stage.
- Consumes the ALU result as a byte address, the Rm value as store data, and the MEM_R_EN/MEM_W_EN controls.
- Performs each 32-bit load/store as two 16-bit accesses on an external SRAM, with a programmable number of wait cycles per access.
- Holds ready low while busy so the hazard/freeze logic stalls the whole pipeline.

Parameters:
- WAIT_CYCLES, 3, cycles each 16-bit access is held on the SRAM bus (legal range 1..15).
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- SRAM_AW, 18, SRAM address width in 16-bit halfwords.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- MEM_R_EN  in  1  load request from the EX/MEM register.
- MEM_W_EN  in  1  store request from the EX/MEM register.
- ALU_out  in  32  byte address computed by the execute stage.
- Val_RM  in  32  store data.
- mem_rdata  out  32  load result, registered.
- ready  out  1  high when the pipeline may advance.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq_out  out  16  write data driven toward SRAM.
- sram_dq_oe  out  1  tri-state enable for sram_dq_out (top level builds the inout).
- sram_dq_in  in  16  data read back from SRAM.
- sram_we_n  out  1  active-low write strobe.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values:
  - state IDLE, wait counter 0, mem_rdata 0.
  - sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1.
  - ready follows its combinational rule, so it is 1 when no request is asserted.
- Address mapping:
  - off = ALU_out - BASE_ADDR (32-bit, wraps modulo 2^32).
  - word = off[SRAM_AW:2] (SRAM_AW-1 bits; upper bits ignored).
  - Low halfword address = {word,1'b0}; high halfword address = {word,1'b1}.
  - ALU_out[1:0] is ignored, i.e. accesses are always word-aligned.
- req = MEM_R_EN | MEM_W_EN.
- If both enables are high, the access is a store; this combination is illegal upstream and has no other effect.
- FSM states:
  - IDLE: if req, latch the write flag, address and Val_RM into internal registers, load counter = WAIT_CYCLES-1, go to LO. Otherwise stay in IDLE.
  - LO: drive the low halfword address.
    - Write: sram_dq_out = data[15:0], oe = 1, we_n = 0.
    - Read: oe = 0, we_n = 1.
    - Decrement the counter each cycle. In the cycle the counter is 0: a read captures sram_dq_in into rdata[15:0], the counter reloads, and the FSM goes to HI.
  - HI: same as LO, using the high halfword address and data[31:16]. A read captures into rdata[31:16]. When the counter reaches 0, go to DONE.
  - DONE: we_n = 1, oe = 0. Go to IDLE on the next edge.
- sram_we_n is deasserted (1) on the final wait cycle of each write access, giving one cycle of address/data hold after the strobe.
  - With WAIT_CYCLES = 1 the strobe is a single low cycle, and the address holds into the next state.
- ready (combinational): ready = ~req in IDLE, 0 in LO and HI, 1 in DONE.
- Latency:
  - A request accepted at edge N gives ready = 1 during cycle N + 2*WAIT_CYCLES.
  - The stall is exactly 2*WAIT_CYCLES+1 cycles with ready low, counting the IDLE request cycle.
- mem_rdata updates only on a read capture. It holds its value across stores and idle cycles.
- Request inputs are frozen by upstream while ready = 0. Changes to them in LO/HI/DONE are ignored because the operands are latched.
- In DONE, req is still asserted (the pipeline advances at this edge). The FSM must return to IDLE without re-triggering.
  - A new request is recognised only in IDLE on the following cycle.
- Asynchronous reset mid-access: immediately force IDLE and the reset outputs. we_n goes to 1 the same cycle.
  - A partially written word is permitted.
  - The half-captured read is discarded because mem_rdata resets to 0.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3.
  - the BASE_ADDR default, 1024.
  - the SRAM width constants, 16 data / 18 address.
- One natural sub-module, sram_wait_counter: loadable down-counter with a zero flag, reused for each half.

Test Plan:
- Reset: assert rst mid-LO of a store with WAIT_CYCLES = 3 -> the same cycle gives we_n = 1, oe = 0, state IDLE; after release, ready = 1 and mem_rdata = 0.
- Store then load: store Val_RM = 0xDEADBEEF at ALU_out = 1028 -> the SRAM model holds hw[2] = 0xBEEF and hw[3] = 0xDEAD. A later load of 1028 gives mem_rdata = 0xDEADBEEF, and ready is low for exactly 7 cycles each.
- Latency sweep: WAIT_CYCLES = 1 and 5 -> stall lengths of 3 and 11 cycles; we_n low for 1 cycle and 4 cycles per half respectively.
- Address boundaries:
  - ALU_out = 1024 gives sram_addr 0/1.
  - ALU_out = 1027 (unaligned) gives word 0.
  - ALU_out = 1020 wraps to the top word, sram_addr 0x3FFFE/0x3FFFF.
- Back-to-back load-load with req held through DONE -> a second access starts only after one IDLE cycle. The first mem_rdata value is stable until the second capture. There is no spurious third access.
- No request for 20 cycles -> ready constant 1, we_n constant 1, oe 0, mem_rdata unchanged.
